// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD definitions for the modulo counter family.
//                - digit width and maximum digit value
//                - pow10()     : elaboration-time power of ten
//                - to_bcd()    : integer -> packed BCD constant (up to 6 digits)
//                - bcd_valid() : every nibble of a packed BCD vector is <= 9
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int c_BCD_W      = 4;
    localparam int c_BCD_MAX    = 9;
    localparam int c_MAX_DIGITS = 6;
    localparam int c_BCD_VEC_W  = c_BCD_W * c_MAX_DIGITS;

    typedef logic [c_BCD_W-1:0]     bcd_digit_t;
    typedef logic [c_BCD_VEC_W-1:0] bcd_vec_t;

    // 10**n as an integer; used only for parameter legality checks.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Integer to packed BCD, least significant digit in bits [3:0].
    function automatic bcd_vec_t to_bcd(input int value);
        bcd_vec_t r;
        int       v;
        r = '0;
        v = value;
        for (int i = 0; i < c_MAX_DIGITS; i++) begin
            r[c_BCD_W*i +: c_BCD_W] = c_BCD_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // True when every nibble holds a decimal digit.
    function automatic logic bcd_valid(input bcd_vec_t v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < c_MAX_DIGITS; i++) begin
            if (v[c_BCD_W*i +: c_BCD_W] > bcd_digit_t'(c_BCD_MAX)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_counter_if
//  Description : Control/data bundle of one BCD modulo counter.
//                master (driver side) : en, up, load, din   -> counter
//                slave  (counter side): q, tc, load_err     -> driver
//                en       count enable
//                up       1 = count up, 0 = count down
//                load     synchronous parallel load of din
//                din      BCD load value, digit i in [4i+3:4i]
//                q        current BCD count
//                tc       combinational terminal count (cascade into next en)
//                load_err registered one-cycle pulse after a rejected load
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_mod_counter_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);

    logic                       en;
    logic                       up;
    logic                       load;
    logic [c_BCD_W*DIGITS-1:0]  din;
    logic [c_BCD_W*DIGITS-1:0]  q;
    logic                       tc;
    logic                       load_err;

    modport master (
        output en, up, load, din,
        input  q, tc, load_err
    );

    modport slave (
        input  en, up, load, din,
        output q, tc, load_err
    );

endinterface : bcd_mod_counter_if
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One 4-bit BCD digit register with up/down step.
//                Ports:
//                  clk      rising-edge clock
//                  reset    asynchronous active-low clear
//                  i_step   carry (up) / borrow (down) in; digit steps when 1
//                  i_up     direction, 1 = up
//                  i_load   synchronous load of i_din (wins over i_step)
//                  i_din    value to load
//                  o_q      digit value
//                  o_carry  carry/borrow out: stepping past 9 (up) or 0 (down)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_step,
    input  logic       i_up,
    input  logic       i_load,
    input  bcd_digit_t i_din,
    output bcd_digit_t o_q,
    output logic       o_carry
);

    localparam bcd_digit_t c_DIG_MAX = bcd_digit_t'(c_BCD_MAX);

    bcd_digit_t r_q;
    bcd_digit_t w_next;

    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = i_din;
        end else if (i_step) begin
            if (i_up) begin
                // >= rather than == so an unexpected nibble still returns to 0
                w_next = (r_q >= c_DIG_MAX) ? '0 : r_q + bcd_digit_t'(1);
            end else begin
                w_next = (r_q == '0) ? c_DIG_MAX : r_q - bcd_digit_t'(1);
            end
        end
    end

    assign o_carry = i_step & (i_up ? (r_q == c_DIG_MAX) : (r_q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_counter
//  Description : Synchronous BCD counter, modulo MODULO, DIGITS digits wide.
//                Enable, up/down, parallel load with validation, cascadable
//                terminal count. Edge priority: load > en > hold.
//                Ports:
//                  clk    rising-edge clock
//                  reset  asynchronous active-low reset (q = 0, load_err = 0)
//                  cif    bcd_mod_counter_if.slave: en, up, load, din in;
//                         q, tc, load_err out
//                Parameters:
//                  DIGITS 1..6, MODULO 2..10**DIGITS
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MODULO = 60
)(
    input  logic             clk,
    input  logic             reset,
    bcd_mod_counter_if.slave cif
);

    localparam int             c_W        = c_BCD_W * DIGITS;
    localparam bcd_vec_t       c_MAX_FULL = to_bcd(MODULO - 1);
    // BCD image of MODULO-1: both the up-wrap point and the down-wrap reload value
    localparam logic [c_W-1:0] c_MAX_BCD  = c_MAX_FULL[c_W-1:0];

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    generate
        if (DIGITS < 1 || DIGITS > c_MAX_DIGITS) begin : g_bad_digits
            $error("bcd_mod_counter: DIGITS=%0d outside 1..%0d", DIGITS, c_MAX_DIGITS);
        end
        if (MODULO < 2 || MODULO > pow10(DIGITS)) begin : g_bad_modulo
            $error("bcd_mod_counter: MODULO=%0d outside 2..10**DIGITS", MODULO);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [c_W-1:0]  w_q;
    logic [c_W-1:0]  w_din;
    logic [c_W-1:0]  w_load_val;
    logic [DIGITS:0] w_step;       // [0] = count request, [i] = carry into digit i
    logic            w_din_ok;
    logic            w_at_max;
    logic            w_at_zero;
    logic            w_wrap;
    logic            w_dig_load;
    logic            w_load_rej;
    logic            r_load_err;

    assign w_din = cif.din;

    // For well-formed BCD, numeric order equals order of the packed encoding,
    // so "value < MODULO" is a plain compare against MODULO-1 in BCD.
    // This also covers MODULO = 10**DIGITS, which has no DIGITS-wide BCD form.
    assign w_din_ok = bcd_valid(bcd_vec_t'(w_din)) && (w_din <= c_MAX_BCD);

    assign w_at_max  = (w_q == c_MAX_BCD);
    assign w_at_zero = (w_q == '0);

    assign w_step[0] = cif.en & ~cif.load;

    // A carry/borrow out of the top digit can only occur at q = 99..9 (up,
    // MODULO = 10**DIGITS) or q = 0 (down); both are already wrap points, so
    // folding it in only makes the wrap robust.
    assign w_wrap = (w_step[0] & (cif.up ? w_at_max : w_at_zero)) | w_step[DIGITS];

    // Modulo wrap and parallel load both use the digits' load path.
    assign w_dig_load = cif.load | w_wrap;

    always_comb begin
        w_load_val = '0;
        if (cif.load) begin
            if (w_din_ok) begin
                w_load_val = w_din;
            end
        end else if (!cif.up) begin
            w_load_val = c_MAX_BCD;
        end
    end

    // ------------------------------------------------------------------
    // Digit chain
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk     (clk),
                .reset   (reset),
                .i_step  (w_step[i]),
                .i_up    (cif.up),
                .i_load  (w_dig_load),
                .i_din   (w_load_val[c_BCD_W*i +: c_BCD_W]),
                .o_q     (w_q[c_BCD_W*i +: c_BCD_W]),
                .o_carry (w_step[i+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rejected-load pulse
    // ------------------------------------------------------------------
    assign w_load_rej = cif.load & ~w_din_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_load_rej;
        end
    end

    assign cif.q        = w_q;
    assign cif.tc       = w_wrap;
    assign cif.load_err = r_load_err;

endmodule : bcd_mod_counter
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_mod_counter
//  Description : Self-checking bench for bcd_mod_counter. Four instances:
//                a (2 digits mod 60, seconds), m (mod 60 minutes fed by a.tc),
//                b (3 digits mod 1000), c (2 digits mod 24). Expected values
//                come from an integer reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_mod_counter;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_mod_counter_if #(.DIGITS(2)) if_a ();
    bcd_mod_counter_if #(.DIGITS(2)) if_m ();
    bcd_mod_counter_if #(.DIGITS(3)) if_b ();
    bcd_mod_counter_if #(.DIGITS(2)) if_c ();

    assign if_m.en = if_a.tc;

    bcd_mod_counter #(.DIGITS(2), .MODULO(60))   dut_a (.clk(clk), .reset(reset), .cif(if_a));
    bcd_mod_counter #(.DIGITS(2), .MODULO(60))   dut_m (.clk(clk), .reset(reset), .cif(if_m));
    bcd_mod_counter #(.DIGITS(3), .MODULO(1000)) dut_b (.clk(clk), .reset(reset), .cif(if_b));
    bcd_mod_counter #(.DIGITS(2), .MODULO(24))   dut_c (.clk(clk), .reset(reset), .cif(if_c));

    int checks = 0;
    int errors = 0;

    // reference model state: plain integers
    int ea, em, eb, ec;
    bit eerr_a, eerr_m, eerr_b, eerr_c;

    function automatic logic [23:0] bcd_of(input int v);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // an edge wraps when counting is enabled, no load, and at the end of range
    function automatic bit exp_tc(input int cur, input int m, input bit en, input bit up, input bit load);
        return en && !load && (up ? (cur == m - 1) : (cur == 0));
    endfunction

    task automatic model_step(inout int cur, inout bit err, input int m, input int nd,
                              input bit en, input bit up, input bit load, input logic [23:0] din);
        int val;
        int w;
        bit ok;
        err = 1'b0;
        if (load) begin
            ok  = 1'b1;
            val = 0;
            w   = 1;
            for (int i = 0; i < nd; i++) begin
                if (din[4*i +: 4] > 4'd9) ok = 1'b0;
                val = val + int'(din[4*i +: 4]) * w;
                w   = w * 10;
            end
            if (ok && val < m) cur = val;
            else begin
                cur = 0;
                err = 1'b1;
            end
        end else if (en) begin
            cur = up ? (cur + 1) % m : (cur + m - 1) % m;
        end
    endtask

    task automatic models_reset();
        ea = 0; em = 0; eb = 0; ec = 0;
        eerr_a = 0; eerr_m = 0; eerr_b = 0; eerr_c = 0;
    endtask

    // advance one clock: update models from the current drive, then land on negedge
    task automatic tick();
        bit tc_a;
        tc_a = exp_tc(ea, 60, if_a.en, if_a.up, if_a.load);
        model_step(ea, eerr_a, 60,   2, if_a.en, if_a.up, if_a.load, 24'(if_a.din));
        model_step(em, eerr_m, 60,   2, tc_a,    if_m.up, if_m.load, 24'(if_m.din));
        model_step(eb, eerr_b, 1000, 3, if_b.en, if_b.up, if_b.load, 24'(if_b.din));
        model_step(ec, eerr_c, 24,   2, if_c.en, if_c.up, if_c.load, 24'(if_c.din));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_a.en = 0; if_a.up = 1; if_a.load = 0; if_a.din = '0;
        if_m.up = 1; if_m.load = 0; if_m.din = '0;
        if_b.en = 0; if_b.up = 1; if_b.load = 0; if_b.din = '0;
        if_c.en = 0; if_c.up = 1; if_c.load = 0; if_c.din = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        if_a.load = 1; if_a.din = 8'h45; if_a.en = 1;
        repeat (3) @(negedge clk);
        models_reset();
        checks++; if (if_a.q !== 8'h00)   begin errors++; $display("FAIL reset_q_a: got %h want 00", if_a.q); end
        checks++; if (if_a.load_err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b want 0", if_a.load_err); end
        checks++; if (if_b.q !== 12'h000) begin errors++; $display("FAIL reset_q_b: got %h want 000", if_b.q); end
        checks++; if (if_m.q !== 8'h00)   begin errors++; $display("FAIL reset_q_m: got %h want 00", if_m.q); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_count_up();
        if_a.en = 1; if_a.up = 1; if_a.load = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            checks++;
            if (if_a.tc !== exp_tc(ea, 60, 1, 1, 0)) begin
                errors++; $display("FAIL up_tc at %0d: got %b want %b", ea, if_a.tc, exp_tc(ea, 60, 1, 1, 0));
            end
            tick();
            checks++;
            if (24'(if_a.q) !== bcd_of(ea)) begin
                errors++; $display("FAIL up_q step %0d: got %h want %h", i, if_a.q, bcd_of(ea));
            end
        end
        checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL up_wrap_final: got %h want 00", if_a.q); end
        checks++; if (if_m.q !== 8'h01) begin errors++; $display("FAIL up_cascade_m: got %h want 01", if_m.q); end
        if_a.en = 0;
    endtask

    task automatic test_count_down();
        logic [7:0] want [3] = '{8'h59, 8'h58, 8'h57};
        if_a.load = 1; if_a.din = 8'h00; if_a.en = 0;
        tick();
        checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL down_load00: got %h want 00", if_a.q); end
        if_a.load = 0; if_a.en = 1; if_a.up = 0;
        #1;
        checks++; if (if_a.tc !== 1'b1) begin errors++; $display("FAIL down_tc_at_00: got %b want 1", if_a.tc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_a.q !== want[i] || 24'(if_a.q) !== bcd_of(ea)) begin
                errors++; $display("FAIL down_q step %0d: got %h want %h", i, if_a.q, want[i]);
            end
            checks++; if (if_a.tc !== 1'b0) begin errors++; $display("FAIL down_tc_mid: got %b want 0", if_a.tc); end
        end
        if_a.en = 0; if_a.up = 1;
    endtask

    task automatic test_load();
        logic [7:0] bad [2] = '{8'h7A, 8'h60};
        if_a.load = 1; if_a.din = 8'h45; if_a.en = 1; if_a.up = 1;
        #1;
        checks++; if (if_a.tc !== 1'b0) begin errors++; $display("FAIL load_tc_gated: got %b want 0", if_a.tc); end
        tick();
        checks++; if (if_a.q !== 8'h45) begin errors++; $display("FAIL load_wins: got %h want 45", if_a.q); end
        checks++; if (if_a.load_err !== 1'b0) begin errors++; $display("FAIL load_ok_err: got %b want 0", if_a.load_err); end
        if_a.load = 0;
        tick();
        checks++; if (if_a.q !== 8'h46) begin errors++; $display("FAIL load_then_up: got %h want 46", if_a.q); end
        for (int i = 0; i < 2; i++) begin
            if_a.load = 1; if_a.din = bad[i]; if_a.en = 0;
            tick();
            checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL bad_load_q %h: got %h want 00", bad[i], if_a.q); end
            checks++; if (if_a.load_err !== 1'b1) begin errors++; $display("FAIL bad_load_err %h: got %b want 1", bad[i], if_a.load_err); end
            if_a.load = 0;
            tick();
            checks++; if (if_a.load_err !== 1'b0) begin errors++; $display("FAIL bad_load_pulse %h: got %b want 0", bad[i], if_a.load_err); end
            checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL bad_load_hold %h: got %h want 00", bad[i], if_a.q); end
        end
    endtask

    task automatic test_async_reset();
        if_a.load = 1; if_a.din = 8'h30; if_a.en = 0;
        tick();
        if_a.load = 0; if_a.en = 1; if_a.up = 1;
        repeat (7) tick();
        checks++; if (if_a.q !== 8'h37) begin errors++; $display("FAIL pre_reset_q: got %h want 37", if_a.q); end
        #2;
        reset = 1'b0;
        if_a.load = 1; if_a.din = 8'h12;
        models_reset();
        #1;
        checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL async_reset_q: got %h want 00", if_a.q); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL reset_discards_load: got %h want 00", if_a.q); end
        reset = 1'b1;
        if_a.load = 0; if_a.en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (if_a.q !== 8'h00) begin errors++; $display("FAIL hold_after_reset %0d: got %h want 00", i, if_a.q); end
        end
    endtask

    task automatic test_wide_and_mod24();
        if_b.load = 1; if_b.din = 12'h998; if_b.en = 1; if_b.up = 1;
        if_c.load = 1; if_c.din = 8'h23;   if_c.en = 0;
        tick();
        checks++; if (if_b.q !== 12'h998) begin errors++; $display("FAIL b_load: got %h want 998", if_b.q); end
        checks++; if (if_c.q !== 8'h23)   begin errors++; $display("FAIL c_load: got %h want 23", if_c.q); end
        if_b.load = 0; if_c.load = 0; if_c.en = 1; if_c.up = 1;
        #1;
        checks++; if (if_b.tc !== 1'b0) begin errors++; $display("FAIL b_tc_998: got %b want 0", if_b.tc); end
        checks++; if (if_c.tc !== 1'b1) begin errors++; $display("FAIL c_tc_23: got %b want 1", if_c.tc); end
        tick();
        checks++; if (if_b.q !== 12'h999) begin errors++; $display("FAIL b_999: got %h want 999", if_b.q); end
        checks++; if (if_c.q !== 8'h00)   begin errors++; $display("FAIL c_wrap: got %h want 00", if_c.q); end
        if_c.en = 0;
        #1;
        checks++; if (if_b.tc !== 1'b1) begin errors++; $display("FAIL b_tc_999: got %b want 1", if_b.tc); end
        tick();
        checks++; if (if_b.q !== 12'h000) begin errors++; $display("FAIL b_wrap: got %h want 000", if_b.q); end
        if_b.en = 0;
    endtask

    task automatic test_cascade();
        logic [7:0] prev_a, prev_m;
        int         m_steps;
        if_a.load = 1; if_a.din = 8'h00; if_a.en = 0;
        if_m.load = 1; if_m.din = 8'h00; if_m.up = 1;
        tick();
        if_a.load = 0; if_m.load = 0; if_a.en = 1; if_a.up = 1;
        m_steps = 0;
        for (int i = 0; i < 3600; i++) begin
            prev_a = if_a.q;
            prev_m = if_m.q;
            tick();
            if (if_m.q !== prev_m) begin
                m_steps++;
                checks++;
                if (!(prev_a === 8'h59 && if_a.q === 8'h00)) begin
                    errors++; $display("FAIL cascade_m_step: seconds %h->%h", prev_a, if_a.q);
                end
            end
            checks++;
            if (24'(if_m.q) !== bcd_of(em) || 24'(if_a.q) !== bcd_of(ea)) begin
                errors++; $display("FAIL cascade_q edge %0d: got %h:%h want %h:%h", i, if_m.q, if_a.q, bcd_of(em), bcd_of(ea));
            end
        end
        checks++; if (m_steps != 60) begin errors++; $display("FAIL cascade_m_count: got %0d want 60", m_steps); end
        checks++; if ({if_m.q, if_a.q} !== 16'h0000) begin errors++; $display("FAIL cascade_final: got %h want 0000", {if_m.q, if_a.q}); end
        if_a.en = 0;
    endtask

    function automatic logic [23:0] rand_din(input int m);
        if ($urandom_range(0, 3) == 0) return 24'($urandom);
        return bcd_of($urandom_range(0, m + m / 4));
    endfunction

    task automatic test_random();
        bit tc_a;
        for (int i = 0; i < 400; i++) begin
            if_a.en = ($urandom_range(0, 3) != 0); if_a.up = 1'($urandom); if_a.load = ($urandom_range(0, 7) == 0); if_a.din = 8'(rand_din(60));
            if_m.up = 1'($urandom); if_m.load = ($urandom_range(0, 7) == 0); if_m.din = 8'(rand_din(60));
            if_b.en = ($urandom_range(0, 3) != 0); if_b.up = 1'($urandom); if_b.load = ($urandom_range(0, 7) == 0); if_b.din = 12'(rand_din(1000));
            if_c.en = ($urandom_range(0, 3) != 0); if_c.up = 1'($urandom); if_c.load = ($urandom_range(0, 7) == 0); if_c.din = 8'(rand_din(24));
            #1;
            tc_a = exp_tc(ea, 60, if_a.en, if_a.up, if_a.load);
            checks++;
            if ({if_a.tc, if_m.tc, if_b.tc, if_c.tc} !==
                {tc_a, exp_tc(em, 60, tc_a, if_m.up, if_m.load),
                 exp_tc(eb, 1000, if_b.en, if_b.up, if_b.load), exp_tc(ec, 24, if_c.en, if_c.up, if_c.load)}) begin
                errors++; $display("FAIL rand_tc iter %0d: got %b%b%b%b", i, if_a.tc, if_m.tc, if_b.tc, if_c.tc);
            end
            tick();
            checks++;
            if (24'(if_a.q) !== bcd_of(ea) || if_a.load_err !== eerr_a) begin
                errors++; $display("FAIL rand_a iter %0d: got %h/%b want %h/%b", i, if_a.q, if_a.load_err, bcd_of(ea), eerr_a);
            end
            checks++;
            if (24'(if_m.q) !== bcd_of(em) || if_m.load_err !== eerr_m) begin
                errors++; $display("FAIL rand_m iter %0d: got %h/%b want %h/%b", i, if_m.q, if_m.load_err, bcd_of(em), eerr_m);
            end
            checks++;
            if (24'(if_b.q) !== bcd_of(eb) || if_b.load_err !== eerr_b) begin
                errors++; $display("FAIL rand_b iter %0d: got %h/%b want %h/%b", i, if_b.q, if_b.load_err, bcd_of(eb), eerr_b);
            end
            checks++;
            if (24'(if_c.q) !== bcd_of(ec) || if_c.load_err !== eerr_c) begin
                errors++; $display("FAIL rand_c iter %0d: got %h/%b want %h/%b", i, if_c.q, if_c.load_err, bcd_of(ec), eerr_c);
            end
        end
        idle_inputs();
    endtask

    initial begin
        models_reset();
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_async_reset();
        test_wide_and_mod24();
        test_cascade();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bcd_mod_counter
`default_nettype wire
